srt4_host_ctrl: RTL and testbench

Host-side driver for the SRT radix-4 divider operand/result bus. It accepts a 16-bit dividend and an 8-bit divisor over a valid/ready request channel. It pulses beginSignal and streams the operands byte-serially on inbus, then waits for endSignal and collects quotient and remainder from outbus. It returns them with a status code on a valid/ready response channel. It screens out divide-by-zero and quotient overflow without starting the divider, and it bounds every run with a timeout.

---
 rtl/srt4_pkg.sv | 28 ++
 rtl/srt4_host_ctrl_timeout_cnt.sv | 31 +++
 rtl/srt4_host_ctrl.sv | 144 ++++++++++++++
 tb/tb_srt4_host_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/srt4_pkg.sv
// Shared types and constants for the SRT radix-4 divider host controller.
// Covers the FSM states, response status codes and operand byte order.
package srt4_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_HI,
        S_LD_LO,
        S_LD_DIV,
        S_WAIT,
        S_CAP_R,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_DIV_ZERO = 2'b01;
    localparam logic [1:0] ST_OVERFLOW = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    // Dividend goes out high byte first, then low byte, then the divisor.
    localparam logic OP_HI = 1'b1;
    localparam logic OP_LO = 1'b0;

    function automatic logic [7:0] op_byte(input logic [15:0] dividend, input logic hi);
        return hi ? dividend[15:8] : dividend[7:0];
    endfunction

endpackage

// File: rtl/srt4_host_ctrl_timeout_cnt.sv
// Clear/enable cycle counter for bounding the divider wait.
// The terminal flag is raised while the count sits at TIMEOUT_CYCLES-1.
module srt4_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_terminal = w_terminal;

    // Holds at terminal so the count never wraps back below the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_terminal) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/srt4_host_ctrl.sv
// Host-side driver for the SRT radix-4 divider: screens operands, streams them
// byte-serially, collects quotient/remainder and returns them with a status.
module srt4_host_ctrl
    import srt4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_dividend,
    input  logic [7:0]  req_divisor,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_quotient,
    output logic [7:0]  resp_remainder,
    output logic [1:0]  resp_status,
    output logic        beginSignal,
    output logic [7:0]  inbus,
    input  logic [7:0]  outbus,
    input  logic        endSignal
);
    state_t      r_state;
    logic [15:0] r_dividend;
    logic [7:0]  r_divisor;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [7:0]  r_resp_quotient;
    logic [7:0]  r_resp_remainder;
    logic [1:0]  r_resp_status;
    logic        r_begin;
    logic [7:0]  r_inbus;
    logic        w_expired;

    srt4_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_state == S_LD_DIV),
        .i_enable   (r_state == S_WAIT),
        .o_terminal (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_dividend       <= '0;
            r_divisor        <= '0;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_quotient  <= '0;
            r_resp_remainder <= '0;
            r_resp_status    <= ST_OK;
            r_begin          <= 1'b0;
            r_inbus          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_begin <= 1'b0;
                    r_inbus <= '0;
                    if (req_valid && r_req_ready) begin
                        r_dividend  <= req_dividend;
                        r_divisor   <= req_divisor;
                        r_req_ready <= 1'b0;
                        // Quotient only fits in 8 bits when dividend[15:8] < divisor.
                        if (req_divisor == 8'h00) begin
                            r_state          <= S_RESP;
                            r_resp_valid     <= 1'b1;
                            r_resp_status    <= ST_DIV_ZERO;
                            r_resp_quotient  <= 8'hFF;
                            r_resp_remainder <= 8'h00;
                        end else if (req_dividend[15:8] >= req_divisor) begin
                            r_state          <= S_RESP;
                            r_resp_valid     <= 1'b1;
                            r_resp_status    <= ST_OVERFLOW;
                            r_resp_quotient  <= 8'hFF;
                            r_resp_remainder <= 8'h00;
                        end else begin
                            r_state <= S_LD_HI;
                            r_begin <= 1'b1;
                            r_inbus <= op_byte(req_dividend, OP_HI);
                        end
                    end
                end
                S_LD_HI: begin
                    r_state <= S_LD_LO;
                    r_begin <= 1'b0;
                    r_inbus <= op_byte(r_dividend, OP_LO);
                end
                S_LD_LO: begin
                    r_state <= S_LD_DIV;
                    r_inbus <= r_divisor;
                end
                S_LD_DIV: begin
                    r_state <= S_WAIT;
                    r_inbus <= '0;
                end
                S_WAIT: begin
                    if (endSignal) begin
                        r_state         <= S_CAP_R;
                        r_resp_quotient <= outbus;
                    end else if (w_expired) begin
                        r_state          <= S_RESP;
                        r_resp_valid     <= 1'b1;
                        r_resp_status    <= ST_TIMEOUT;
                        r_resp_quotient  <= 8'h00;
                        r_resp_remainder <= 8'h00;
                    end
                end
                S_CAP_R: begin
                    r_state          <= S_RESP;
                    r_resp_valid     <= 1'b1;
                    r_resp_status    <= ST_OK;
                    r_resp_remainder <= outbus;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_begin      <= 1'b0;
                    r_inbus      <= '0;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_quotient  = r_resp_quotient;
    assign resp_remainder = r_resp_remainder;
    assign resp_status    = r_resp_status;
    assign beginSignal    = r_begin;
    assign inbus          = r_inbus;

endmodule

// File: tb/tb_srt4_host_ctrl.sv
// Self-checking bench for srt4_host_ctrl: directed plan steps plus random runs
// against a cycle-level behavioural model of the request/response protocol.
module tb_srt4_host_ctrl;
    localparam int TO = 64;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_dividend;
    logic [7:0]  req_divisor;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_quotient;
    logic [7:0]  resp_remainder;
    logic [1:0]  resp_status;
    logic        beginSignal;
    logic [7:0]  inbus;
    logic [7:0]  outbus;
    logic        endSignal;

    int total = 0;
    int bad   = 0;

    srt4_host_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_status    (resp_status),
        .beginSignal    (beginSignal),
        .inbus          (inbus),
        .outbus         (outbus),
        .endSignal      (endSignal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 16'(req_ready), 16'd1);
        chk({tag, "_resp_valid"}, 16'(resp_valid), 16'd0);
        chk({tag, "_begin"}, 16'(beginSignal), 16'd0);
        chk({tag, "_inbus"}, 16'(inbus), 16'd0);
    endtask

    // d: endSignal arrives d cycles after the divisor byte (<=0 means never).
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input int d,
                          input logic [7:0] qb, input logic [7:0] rb, input int hold,
                          input bit late, input bit spur);
        int         ce;
        int         rc;
        int         waitc;
        bit         normal;
        logic [1:0] es;
        logic [7:0] eq;
        logic [7:0] er;
        logic [7:0] ein;

        normal = 1'b0;
        ce     = -10;
        if (dvs == 8'h00) begin
            es = 2'b01; eq = 8'hFF; er = 8'h00; rc = 1;
        end else if (dvd[15:8] >= dvs) begin
            es = 2'b10; eq = 8'hFF; er = 8'h00; rc = 1;
        end else begin
            normal = 1'b1;
            if (d >= 1 && d <= TO) begin
                ce = 3 + d; es = 2'b00; eq = qb; er = rb; rc = ce + 2;
            end else begin
                es = 2'b11; eq = 8'h00; er = 8'h00; rc = 3 + TO + 1;
            end
        end

        waitc = 0;
        while (!req_ready && waitc < 200) begin
            tick;
            waitc++;
        end
        chk("req_ready_at_start", 16'(req_ready), 16'd1);

        req_valid    = 1'b1;
        req_dividend = dvd;
        req_divisor  = dvs;
        resp_ready   = 1'b0;
        tick;
        req_valid    = 1'b0;
        req_dividend = 16'($urandom);
        req_divisor  = 8'($urandom);

        for (int c = 1; c <= rc; c++) begin
            endSignal = (c == ce) || (spur && normal && c == 2);
            outbus    = (c == ce) ? qb : (c == ce + 1) ? rb : 8'($urandom);
            ein = 8'h00;
            if (normal && c == 1) ein = dvd[15:8];
            if (normal && c == 2) ein = dvd[7:0];
            if (normal && c == 3) ein = dvs;
            chk("begin", 16'(beginSignal), 16'(normal && c == 1));
            chk("inbus", 16'(inbus), 16'(ein));
            chk("resp_valid_timing", 16'(resp_valid), 16'(c == rc));
            chk("req_ready_busy", 16'(req_ready), 16'd0);
            if (c < rc) tick;
        end

        for (int h = 0; h <= hold; h++) begin
            endSignal = late;
            outbus    = 8'($urandom);
            chk("resp_valid_hold", 16'(resp_valid), 16'd1);
            chk("resp_quotient", 16'(resp_quotient), 16'(eq));
            chk("resp_remainder", 16'(resp_remainder), 16'(er));
            chk("resp_status", 16'(resp_status), 16'(es));
            chk("req_ready_resp", 16'(req_ready), 16'd0);
            chk("begin_resp", 16'(beginSignal), 16'd0);
            chk("inbus_resp", 16'(inbus), 16'd0);
            resp_ready = (h == hold);
            tick;
        end
        resp_ready = 1'b0;
        endSignal  = late;
        chk_idle_outputs("after_resp");
        tick;
        endSignal = 1'b0;
        chk_idle_outputs("idle_next");
        $display("run dvd=%h dvs=%h d=%0d -> status=%b q=%h r=%h (expected %b %h %h)",
                 dvd, dvs, d, resp_status, resp_quotient, resp_remainder, es, eq, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  hi;
        int          kind;
        int          d;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_dividend = 16'h0;
        req_divisor  = 8'h0;
        resp_ready   = 1'b0;
        outbus       = 8'h0;
        endSignal    = 1'b0;
        #2;
        chk_idle_outputs("reset");
        chk("reset_quotient", 16'(resp_quotient), 16'd0);
        chk("reset_remainder", 16'(resp_remainder), 16'd0);
        chk("reset_status", 16'(resp_status), 16'd0);
        tick;
        tick;
        rst = 1'b0;
        tick;

        run_op(16'h1234, 8'h56, 8, 8'h36, 8'h10, 0, 1'b0, 1'b0);
        run_op(16'h00FF, 8'h00, 8, 8'h00, 8'h00, 0, 1'b0, 1'b0);
        run_op(16'h5600, 8'h56, 8, 8'h00, 8'h00, 0, 1'b0, 1'b0);
        run_op(16'h1234, 8'h56, -1, 8'h00, 8'h00, 3, 1'b1, 1'b0);
        run_op(16'h1234, 8'h56, 8, 8'h36, 8'h10, 10, 1'b0, 1'b1);
        run_op(16'h0FFF, 8'h20, TO, 8'h7F, 8'h1F, 0, 1'b0, 1'b0);
        run_op(16'h0FFF, 8'h20, TO + 1, 8'h7F, 8'h1F, 0, 1'b0, 1'b0);

        // Abandon a run while waiting for the divider.
        req_valid    = 1'b1;
        req_dividend = 16'h1234;
        req_divisor  = 8'h56;
        tick;
        req_valid = 1'b0;
        for (int c = 1; c < 7; c++) tick;
        #3;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_reset");
        chk("async_reset_status", 16'(resp_status), 16'd0);
        tick;
        #2;
        rst        = 1'b0;
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk_idle_outputs("post_reset");
        end
        resp_ready = 1'b0;
        run_op(16'h0100, 8'h02, 5, 8'h80, 8'h00, 1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            kind = int'($urandom_range(0, 7));
            d    = int'($urandom_range(1, TO + 6));
            if (kind == 0) begin
                dvs = 8'h00;
                dvd = 16'($urandom);
            end else if (kind == 1) begin
                dvs = 8'($urandom_range(1, 255));
                dvd = {8'($urandom_range(int'(dvs), 255)), 8'($urandom)};
            end else begin
                dvs = 8'($urandom_range(1, 255));
                hi  = 8'($urandom_range(0, int'(dvs) - 1));
                dvd = {hi, 8'($urandom)};
            end
            if (dvs == 8'h00) begin
                run_op(dvd, dvs, d, 8'h00, 8'h00, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            end else begin
                run_op(dvd, dvs, d, 8'(dvd / 16'(dvs)), 8'(dvd % 16'(dvs)),
                       int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
